// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// pc_pkg : next-PC select encodings and fetch-sequencer state encoding,
//          shared by the PC sequencer and the next-PC mux.
// Revision: 1.0
// ============================================================================
package pc_pkg;

    localparam logic [2:0] SEL_PC4    = 3'b000;
    localparam logic [2:0] SEL_JALR   = 3'b001;
    localparam logic [2:0] SEL_JAL    = 3'b010;
    localparam logic [2:0] SEL_BRANCH = 3'b011;
    localparam logic [2:0] SEL_EXC    = 3'b100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        EXEC   = 3'd4,
        UPDATE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : owns the architectural PC and steps one instruction at a time
//                through fetch, decode hand-off, execute outcome and PC update.
// Revision: 1.0
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    input  logic            instr_ready,
    input  logic            ctrl_valid,
    input  logic            ctrl_exception,
    input  logic            ctrl_jalr,
    input  logic            ctrl_jal,
    input  logic            ctrl_branch_taken,
    output logic [2:0]      pc_sel,
    output logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] pc_4,
    input  logic [XLEN-1:0] next_pc,
    output logic            trap,
    output logic [XLEN-1:0] instret
);

    state_t r_state;

    assign imem_req_addr = current_pc;
    assign pc_4          = current_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            current_pc     <= RESET_PC;
            pc_sel         <= SEL_PC4;
            instr          <= '0;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            trap           <= 1'b0;
            instret        <= '0;
        end else begin
            trap <= 1'b0;
            case (r_state)
                // IDLE deliberately ignores imem_rsp_valid to drop stale responses
                IDLE: begin
                    imem_req_valid <= 1'b1;
                    r_state        <= REQ;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        r_state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            pc_sel  <= SEL_EXC;
                            trap    <= 1'b1;
                            r_state <= UPDATE;
                        end else begin
                            instr       <= imem_rsp_data;
                            instr_valid <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (ctrl_valid) begin
                        r_state <= UPDATE;
                        if (ctrl_exception) begin
                            pc_sel <= SEL_EXC;
                            trap   <= 1'b1;
                        end else begin
                            instret <= instret + XLEN'(1);
                            if (ctrl_jalr)
                                pc_sel <= SEL_JALR;
                            else if (ctrl_jal)
                                pc_sel <= SEL_JAL;
                            else if (ctrl_branch_taken)
                                pc_sel <= SEL_BRANCH;
                            else
                                pc_sel <= SEL_PC4;
                        end
                    end
                end
                UPDATE: begin
                    // A misaligned target turns into one extra cycle selecting the exception vector
                    if ((next_pc[1:0] != 2'b00) && (pc_sel != SEL_EXC)) begin
                        pc_sel <= SEL_EXC;
                        trap   <= 1'b1;
                    end else begin
                        current_pc     <= next_pc;
                        pc_sel         <= SEL_PC4;
                        imem_req_valid <= 1'b1;
                        r_state        <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed bench acting as memory, decode, execute and mux,
//                   checked against a per-instruction architectural model.
// Revision: 1.0
// ============================================================================
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] C_EXC_VEC  = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready = 1'b0;
    logic        ctrl_valid = 1'b0;
    logic        ctrl_exception = 1'b0;
    logic        ctrl_jalr = 1'b0;
    logic        ctrl_jal = 1'b0;
    logic        ctrl_branch_taken = 1'b0;
    logic [2:0]  pc_sel;
    logic [31:0] current_pc;
    logic [31:0] pc_4;
    logic [31:0] next_pc;
    logic        trap;
    logic [31:0] instret;

    // Architectural model state
    logic [31:0] model_pc      = C_RESET_PC;
    logic [31:0] model_instret = '0;
    logic [31:0] model_instr   = '0;
    int          model_traps   = 0;
    int          trap_seen     = 0;
    logic [31:0] mux_target    = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int req_cyc[$];

    pc_sequencer #(.XLEN(32), .RESET_PC(C_RESET_PC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .imem_rsp_err      (imem_rsp_err),
        .instr_valid       (instr_valid),
        .instr             (instr),
        .instr_ready       (instr_ready),
        .ctrl_valid        (ctrl_valid),
        .ctrl_exception    (ctrl_exception),
        .ctrl_jalr         (ctrl_jalr),
        .ctrl_jal          (ctrl_jal),
        .ctrl_branch_taken (ctrl_branch_taken),
        .pc_sel            (pc_sel),
        .current_pc        (current_pc),
        .pc_4              (pc_4),
        .next_pc           (next_pc),
        .trap              (trap),
        .instret           (instret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Next-PC mux stand-in: fall-through, exception vector, or the current target
    always_comb begin
        next_pc = mux_target;
        if (pc_sel == SEL_PC4)
            next_pc = pc_4;
        else if (pc_sel == SEL_EXC)
            next_pc = C_EXC_VEC;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    function automatic logic [2:0] model_sel(input logic exc, input logic jalr,
                                             input logic jal, input logic br);
        if (exc)  return SEL_EXC;
        if (jalr) return SEL_JALR;
        if (jal)  return SEL_JAL;
        if (br)   return SEL_BRANCH;
        return SEL_PC4;
    endfunction

    // Per-cycle compare against the model whenever a fetch request is visible
    always @(negedge clk) begin
        if (rst_n) begin
            if (trap) trap_seen++;
            if (imem_req_valid) begin
                check("mdl_req_addr", imem_req_addr, model_pc);
                check("mdl_current_pc", current_pc, model_pc);
                check("mdl_pc_4", pc_4, model_pc + 32'd4);
                check("mdl_instret", instret, model_instret);
                check("mdl_trap_count", 32'(trap_seen), 32'(model_traps));
                check("mdl_pc_sel_idle", 32'(pc_sel), 32'(SEL_PC4));
                check1("mdl_no_issue", instr_valid, 1'b0);
            end
            if (instr_valid)
                check("mdl_instr", instr, model_instr);
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL req_timeout: actual=no request required=request within 40 cycles");
        end
    endtask

    // One instruction end-to-end; entered and left on a negedge
    task automatic do_instr(input logic [31:0] exp_addr, input int req_stall, input int dec_stall,
                            input logic err, input logic exc, input logic jalr, input logic jal,
                            input logic br, input logic [31:0] target, input logic [2:0] exp_sel);
        bit          ok;
        logic [31:0] data;
        logic [31:0] tgt;
        logic [2:0]  sel;
        wait_req(ok);
        if (!ok) return;
        req_cyc.push_back(cyc);
        check("fetch_addr", imem_req_addr, exp_addr);
        data        = exp_addr ^ 32'h1357_9BDF;
        model_instr = data;
        mux_target  = target;
        repeat (req_stall) begin
            @(negedge clk);
            check1("req_hold_valid", imem_req_valid, 1'b1);
            check("req_hold_addr", imem_req_addr, exp_addr);
            check1("req_hold_noissue", instr_valid, 1'b0);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check1("req_drop", imem_req_valid, 1'b0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (err) begin
            check("err_pc_sel", 32'(pc_sel), 32'(exp_sel));
            check1("err_trap", trap, 1'b1);
            check1("err_no_issue", instr_valid, 1'b0);
            model_pc = C_EXC_VEC;
            model_traps++;
            @(negedge clk);
            check1("err_no_issue2", instr_valid, 1'b0);
            return;
        end
        check1("issue_valid", instr_valid, 1'b1);
        check("issue_instr", instr, data);
        repeat (dec_stall) begin
            // Stray execute outcome while still in ISSUE must be ignored
            ctrl_valid     = 1'b1;
            ctrl_exception = 1'b1;
            @(negedge clk);
            check1("issue_hold_valid", instr_valid, 1'b1);
            check("issue_hold_instr", instr, data);
        end
        ctrl_valid     = 1'b0;
        ctrl_exception = 1'b0;
        instr_ready    = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check1("exec_valid_low", instr_valid, 1'b0);
        check("exec_pc_sel", 32'(pc_sel), 32'(SEL_PC4));
        check1("exec_no_trap", trap, 1'b0);
        ctrl_valid        = 1'b1;
        ctrl_exception    = exc;
        ctrl_jalr         = jalr;
        ctrl_jal          = jal;
        ctrl_branch_taken = br;
        @(negedge clk);
        ctrl_valid        = 1'b0;
        ctrl_exception    = 1'b0;
        ctrl_jalr         = 1'b0;
        ctrl_jal          = 1'b0;
        ctrl_branch_taken = 1'b0;
        sel = model_sel(exc, jalr, jal, br);
        check("upd_pc_sel", 32'(pc_sel), 32'(exp_sel));
        check1("upd_trap", trap, exc);
        if (exc) begin
            model_pc = C_EXC_VEC;
            model_traps++;
        end else begin
            model_instret = model_instret + 32'd1;
            tgt = (sel == SEL_PC4) ? model_pc + 32'd4 : target;
            if (tgt[1:0] != 2'b00) begin
                @(negedge clk);
                check("misal_pc_sel", 32'(pc_sel), 32'(SEL_EXC));
                check1("misal_trap", trap, 1'b1);
                check("misal_pc_kept", current_pc, model_pc);
                check1("misal_no_req", imem_req_valid, 1'b0);
                model_pc = C_EXC_VEC;
                model_traps++;
            end else begin
                model_pc = tgt;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_in_wait();
        bit ok;
        wait_req(ok);
        if (!ok) return;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_instret", instret, 32'd0);
        check("arst_pc", current_pc, C_RESET_PC);
        repeat (2) @(negedge clk);
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc_sel", 32'(pc_sel), 32'(SEL_PC4));
        model_pc      = C_RESET_PC;
        model_instret = '0;
        model_traps   = 0;
        trap_seen     = 0;
        // Late response from the aborted fetch arrives while in IDLE
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        rst_n          = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check1("stale_rsp_ignored", instr_valid, 1'b0);
        check1("restart_req", imem_req_valid, 1'b1);
        check("restart_addr", imem_req_addr, C_RESET_PC);
    endtask

    initial begin
        @(negedge clk);
        check("rst_current_pc", current_pc, C_RESET_PC);
        check("rst_pc_4", pc_4, 32'h0000_0104);
        check("rst_pc_sel0", 32'(pc_sel), 32'(SEL_PC4));
        check1("rst_req0", imem_req_valid, 1'b0);
        check1("rst_ivalid0", instr_valid, 1'b0);
        check1("rst_trap0", trap, 1'b0);
        check("rst_instret0", instret, 32'd0);
        check("rst_instr0", instr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Straight-line code at zero wait
        do_instr(32'h0000_0100, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, SEL_PC4);
        do_instr(32'h0000_0104, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, SEL_PC4);
        do_instr(32'h0000_0108, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, SEL_PC4);
        check("spacing_1", 32'(req_cyc[1] - req_cyc[0]), 32'd5);
        check("spacing_2", 32'(req_cyc[2] - req_cyc[1]), 32'd5);
        check("instret_3", instret, 32'd3);

        // Memory and decode back-pressure
        do_instr(32'h0000_010C, 4, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, SEL_PC4);
        // JAL outranks branch-taken
        do_instr(32'h0000_0110, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, SEL_JAL);
        // Exception outranks JALR; not retired
        do_instr(32'h0000_0200, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, SEL_EXC);
        check("instret_exc", instret, 32'd5);
        // Misaligned JALR target
        do_instr(32'h0000_0004, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0203, SEL_JALR);
        check("pc_after_misal", current_pc, 32'h0000_0004);
        // Fetch bus error
        do_instr(32'h0000_0004, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, SEL_EXC);
        // Jump to the top of the address space, then wrap
        do_instr(32'h0000_0004, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, SEL_JAL);
        check("pc_4_wrap", pc_4, 32'h0000_0000);
        do_instr(32'hFFFF_FFFC, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, SEL_PC4);
        do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, SEL_BRANCH);
        check("instret_9", instret, 32'd9);
        check("fetch_after_br", imem_req_addr, 32'h0000_0040);

        reset_in_wait();
        do_instr(32'h0000_0100, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, SEL_PC4);
        check("instret_after_rst", instret, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=still running required=finished by 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
